// File: rtl/gpr_file.sv
// General-purpose register file: DEPTH x WIDTH registers, one load/inc/dec/clear
// write port with zero/carry status, and two registered read ports with write bypass.
module gpr_file #(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              CE,
  input  logic [1:0]        OP,
  input  logic [ADDR_W-1:0] WADDR,
  input  logic [WIDTH-1:0]  D,
  input  logic [ADDR_W-1:0] RAADDR,
  input  logic [ADDR_W-1:0] RBADDR,
  output logic [WIDTH-1:0]  QA,
  output logic [WIDTH-1:0]  QB,
  output logic              Z,
  output logic              C
);

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_INC   = 2'b01,
    OP_DEC   = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [WIDTH-1:0] qa_q, qb_q;
  logic             z_q, c_q;

  logic [WIDTH-1:0] cur;
  logic [WIDTH-1:0] res_d;
  logic             carry_d;
  logic             zero_d;
  logic [WIDTH-1:0] qa_d, qb_d;

  always_comb begin
    cur     = regs_q[WADDR];
    res_d   = '0;
    carry_d = 1'b0;
    unique case (op_e'(OP))
      OP_LOAD:  res_d = D;
      // Wrap detection uses the pre-op value: all-ones wraps up, zero wraps down.
      OP_INC: begin
        res_d   = cur + 1'b1;
        carry_d = &cur;
      end
      OP_DEC: begin
        res_d   = cur - 1'b1;
        carry_d = ~|cur;
      end
      OP_CLEAR: res_d = '0;
      default:  res_d = '0;
    endcase
    zero_d = (res_d == '0);

    // Same-edge bypass so a reader sees the value being written this cycle.
    qa_d = (CE && (RAADDR == WADDR)) ? res_d : regs_q[RAADDR];
    qb_d = (CE && (RBADDR == WADDR)) ? res_d : regs_q[RBADDR];
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      qa_q <= '0;
      qb_q <= '0;
      z_q  <= 1'b0;
      c_q  <= 1'b0;
    end else begin
      if (CE) begin
        regs_q[WADDR] <= res_d;
        z_q           <= zero_d;
        c_q           <= carry_d;
      end
      qa_q <= qa_d;
      qb_q <= qb_d;
    end
  end

  assign QA = qa_q;
  assign QB = qb_q;
  assign Z  = z_q;
  assign C  = c_q;

endmodule

// File: tb/tb_gpr_file.sv
// Bench for gpr_file: directed scenarios plus random ops, scoreboarded against
// an array-based reference model; a monitor pops expectations after each edge.
module tb_gpr_file;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic              CLK;
  logic              CLR;
  logic              CE;
  logic [1:0]        OP;
  logic [2:0]        WADDR;
  logic [WIDTH-1:0]  D;
  logic [2:0]        RAADDR;
  logic [2:0]        RBADDR;
  logic [WIDTH-1:0]  QA;
  logic [WIDTH-1:0]  QB;
  logic              Z;
  logic              C;

  gpr_file #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .CLK(CLK), .CLR(CLR), .CE(CE), .OP(OP), .WADDR(WADDR), .D(D),
    .RAADDR(RAADDR), .RBADDR(RBADDR), .QA(QA), .QB(QB), .Z(Z), .C(C)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct {
    logic [WIDTH-1:0] qa;
    logic [WIDTH-1:0] qb;
    logic             z;
    logic             c;
  } exp_t;

  exp_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Reference model state
  logic [WIDTH-1:0] m_reg [DEPTH];
  logic             m_z, m_c;

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) m_reg[i] = '0;
    m_z = 1'b0;
    m_c = 1'b0;
  endfunction

  function automatic exp_t model_apply(input logic ce, input logic [1:0] op,
                                       input logic [2:0] wa, input logic [WIDTH-1:0] d,
                                       input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r;
    logic             cy;
    r  = '0;
    cy = 1'b0;
    if (ce) begin
      case (op)
        2'd0: r = d;
        2'd1: begin t = {1'b0, m_reg[wa]} + 1; r = t[WIDTH-1:0]; cy = t[WIDTH]; end
        2'd2: begin t = {1'b0, m_reg[wa]} - 1; r = t[WIDTH-1:0]; cy = t[WIDTH]; end
        default: r = '0;
      endcase
      m_reg[wa] = r;
      m_z = (r == 0);
      m_c = cy;
    end
    // Reading the array after the write gives the new value on a same-address read.
    e.qa = m_reg[ra];
    e.qb = m_reg[rb];
    e.z  = m_z;
    e.c  = m_c;
    return e;
  endfunction

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Monitor: one expectation per clock edge taken out of reset
  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (CLR && sb.size() > 0) begin
        e = sb.pop_front();
        vectors++;
        if (QA !== e.qa || QB !== e.qb || Z !== e.z || C !== e.c) begin
          miscompares++;
          $display("FAIL scoreboard: got QA=%h QB=%h Z=%b C=%b, expected QA=%h QB=%h Z=%b C=%b",
                   QA, QB, Z, C, e.qa, e.qb, e.z, e.c);
        end
      end
    end
  end

  task automatic step(input logic ce, input logic [1:0] op, input logic [2:0] wa,
                      input logic [WIDTH-1:0] d, input logic [2:0] ra, input logic [2:0] rb);
    @(negedge CLK);
    CE = ce; OP = op; WADDR = wa; D = d; RAADDR = ra; RBADDR = rb;
    sb.push_back(model_apply(ce, op, wa, d, ra, rb));
  endtask

  task automatic settle();
    @(posedge CLK);
    #2;
  endtask

  task automatic rand_inputs();
    CE = 1'b1;
    OP = 2'($urandom_range(3));
    WADDR = 3'($urandom_range(7));
    D = $urandom;
    RAADDR = 3'($urandom_range(7));
    RBADDR = 3'($urandom_range(7));
  endtask

  initial begin
    logic [WIDTH-1:0] dv;
    int               k;
    CLR = 1'b0;
    rand_inputs();
    model_reset();

    // Reset held with active random traffic
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      rand_inputs();
      @(posedge CLK);
      #1;
      chk("reset_QA", QA, '0);
      chk("reset_QB", QB, '0);
      chk("reset_ZC", {30'd0, Z, C}, '0);
    end
    @(negedge CLK);
    CE = 1'b0;
    CLR = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 2'd0, 3'd0, '0, 3'(i), 3'(i ^ 1));
      settle();
      chk("reset_read", QA, '0);
    end

    // Load and read back
    step(1'b1, 2'd0, 3'd3, 32'h12345678, 3'd0, 3'd0);
    step(1'b1, 2'd0, 3'd5, 32'hABCDEF01, 3'd0, 3'd0);
    step(1'b0, 2'd0, 3'd0, 32'h0, 3'd3, 3'd5);
    settle();
    chk("load_QA", QA, 32'h12345678);
    chk("load_QB", QB, 32'hABCDEF01);
    chk("load_Z", {31'd0, Z}, 32'd0);

    // Increment wrap
    step(1'b1, 2'd0, 3'd2, 32'hFFFFFFFF, 3'd2, 3'd0);
    step(1'b1, 2'd1, 3'd2, 32'h0, 3'd2, 3'd0);
    settle();
    chk("incwrap_QA", QA, 32'h0);
    chk("incwrap_ZC", {30'd0, Z, C}, 32'd3);
    step(1'b1, 2'd1, 3'd2, 32'h0, 3'd2, 3'd0);
    settle();
    chk("inc_QA", QA, 32'h1);
    chk("inc_ZC", {30'd0, Z, C}, 32'd0);

    // Decrement borrow
    step(1'b1, 2'd3, 3'd4, 32'h5555AAAA, 3'd4, 3'd4);
    settle();
    chk("clear_ZC", {30'd0, Z, C}, 32'd2);
    step(1'b1, 2'd2, 3'd4, 32'h0, 3'd4, 3'd4);
    settle();
    chk("dec_QA", QA, 32'hFFFFFFFF);
    chk("dec_ZC", {30'd0, Z, C}, 32'd1);

    // Dual-port bypass, then the same with CE low
    step(1'b1, 2'd0, 3'd6, 32'h87654321, 3'd6, 3'd6);
    settle();
    chk("bypass_QA", QA, 32'h87654321);
    chk("bypass_QB", QB, 32'h87654321);
    step(1'b0, 2'd0, 3'd6, 32'h0, 3'd6, 3'd6);
    settle();
    chk("ce0_QA", QA, 32'h87654321);
    chk("ce0_ZC", {30'd0, Z, C}, 32'd0);

    // Asynchronous reset between edges during an INC stream
    step(1'b1, 2'd0, 3'd1, 32'hFFFFFFFE, 3'd1, 3'd1);
    step(1'b1, 2'd1, 3'd1, 32'h0, 3'd1, 3'd1);
    step(1'b1, 2'd1, 3'd1, 32'h0, 3'd1, 3'd1);
    settle();
    chk("pre_areset_ZC", {30'd0, Z, C}, 32'd3);
    step(1'b1, 2'd1, 3'd1, 32'h0, 3'd1, 3'd1);
    settle();
    CLR = 1'b0;
    #1;
    chk("areset_QA", QA, '0);
    chk("areset_QB", QB, '0);
    chk("areset_ZC", {30'd0, Z, C}, '0);
    model_reset();
    @(negedge CLK);
    rand_inputs();
    @(negedge CLK);
    CE = 1'b0;
    CLR = 1'b1;
    step(1'b1, 2'd1, 3'd1, 32'h0, 3'd1, 3'd2);
    settle();
    chk("post_areset_inc", QA, 32'h1);

    // Random traffic, seeded with boundary data so wraps actually occur
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(3);
      case (k)
        0: dv = 32'h0;
        1: dv = 32'hFFFFFFFF;
        2: dv = 32'h1;
        default: dv = $urandom;
      endcase
      step(1'($urandom_range(3) != 0), 2'($urandom_range(3)), 3'($urandom_range(7)),
           dv, 3'($urandom_range(7)), 3'($urandom_range(7)));
    end
    @(negedge CLK);
    CE = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
